// File: rtl/adc_spi_reader.sv
// adc_spi_reader
//   Serial front end for an 8-channel, 12-bit SPI ADC that uses a 16-SCLK frame,
//   sends data MSB first, and takes the address of the next conversion on DIN.
//   The block drives CS_N, SCLK and DIN, shifts in DOUT, and presents the
//   parallel result with a one-clock valid strobe. All outputs are registered.
//
// Ports
//   clk          system clock (only clock)
//   rst_n        asynchronous active-low reset
//   start        frame request, sampled in IDLE only (hold high = continuous)
//   channel      address sent in this frame (selects the next conversion)
//   adc_cs_n     ADC chip select, active low
//   adc_sclk     ADC serial clock, idles high
//   adc_din      address bits to the ADC
//   adc_dout     serial data from the ADC (used unsynchronised)
//   sample       last completed conversion
//   sample_chan  channel that `sample` belongs to
//   sample_valid one-clock strobe when sample/sample_chan update
//   busy         high in every state except IDLE
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | cs_n high, waiting for start
// SETUP | cs_n low, sclk high for CLK_DIV clocks before the first bit
// SHIFT | 16 bit periods: CLK_DIV clocks sclk low, CLK_DIV clocks sclk high
// DONE  | cs_n high, publish sample and strobe sample_valid (1 clock)
// HOLD  | cs_n held high for CLK_DIV-1 more clocks

module adc_spi_reader #(
  parameter int CLK_DIV      = 4,
  parameter int SAMPLE_WIDTH = 12,
  parameter int CHAN_WIDTH   = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [CHAN_WIDTH-1:0]   channel,
  output logic                    adc_cs_n,
  output logic                    adc_sclk,
  output logic                    adc_din,
  input  logic                    adc_dout,
  output logic [SAMPLE_WIDTH-1:0] sample,
  output logic [CHAN_WIDTH-1:0]   sample_chan,
  output logic                    sample_valid,
  output logic                    busy
);

  localparam int FRAME_BITS = 16;
  localparam int CNT_W      = $clog2(CLK_DIV);
  localparam logic [CNT_W-1:0] DIV_M1   = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] DIV_M2   = CNT_W'(CLK_DIV - 2);
  localparam logic [3:0]       LAST_BIT = 4'(FRAME_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_SHIFT,
    S_DONE,
    S_HOLD
  } state_t;

  state_t                  state_q;
  logic [CNT_W-1:0]        cnt_q;
  logic [3:0]              bit_q;
  logic [CHAN_WIDTH-1:0]   addr_q;
  logic [CHAN_WIDTH-1:0]   prev_chan_q;
  // Only the low SAMPLE_WIDTH bits are kept; the leading bits of the frame
  // fall off the top of the register as the later bits arrive.
  logic [SAMPLE_WIDTH-1:0] shift_q;
  logic                    cs_n_q;
  logic                    sclk_q;
  logic                    din_q;
  logic [SAMPLE_WIDTH-1:0] sample_q;
  logic [CHAN_WIDTH-1:0]   sample_chan_q;
  logic                    valid_q;
  logic                    busy_q;
  logic                    din_d;

  // Address bit carried in bit period k: MSB in period 2, then descending.
  function automatic logic addr_bit(input logic [3:0] k, input logic [CHAN_WIDTH-1:0] a);
    logic b;
    b = 1'b0;
    for (int i = 0; i < CHAN_WIDTH; i++) begin
      if (k == 4'(i + 2)) b = a[CHAN_WIDTH-1-i];
    end
    return b;
  endfunction

  // DIN for the period about to start on the next falling SCLK edge.
  always_comb begin
    din_d = 1'b0;
    din_d = addr_bit(bit_q + 4'd1, addr_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      bit_q         <= '0;
      addr_q        <= '0;
      prev_chan_q   <= '0;
      shift_q       <= '0;
      cs_n_q        <= 1'b1;
      sclk_q        <= 1'b1;
      din_q         <= 1'b0;
      sample_q      <= '0;
      sample_chan_q <= '0;
      valid_q       <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q <= S_SETUP;
            addr_q  <= channel;
            cs_n_q  <= 1'b0;
            sclk_q  <= 1'b1;
            din_q   <= 1'b0;
            busy_q  <= 1'b1;
            cnt_q   <= DIV_M1;
          end
        end

        S_SETUP: begin
          if (cnt_q == '0) begin
            state_q <= S_SHIFT;
            sclk_q  <= 1'b0;
            bit_q   <= '0;
            din_q   <= addr_bit(4'd0, addr_q);
            cnt_q   <= DIV_M1;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end

        S_SHIFT: begin
          // First clock of the high half: DOUT has had a full low half to settle.
          if (sclk_q && cnt_q == DIV_M1) begin
            shift_q <= {shift_q[SAMPLE_WIDTH-2:0], adc_dout};
          end
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
          end else if (!sclk_q) begin
            sclk_q <= 1'b1;
            cnt_q  <= DIV_M1;
          end else if (bit_q == LAST_BIT) begin
            state_q       <= S_DONE;
            cs_n_q        <= 1'b1;
            din_q         <= 1'b0;
            sample_q      <= shift_q;
            sample_chan_q <= prev_chan_q;
            prev_chan_q   <= addr_q;
            valid_q       <= 1'b1;
          end else begin
            bit_q  <= bit_q + 4'd1;
            sclk_q <= 1'b0;
            din_q  <= din_d;
            cnt_q  <= DIV_M1;
          end
        end

        S_DONE: begin
          state_q <= S_HOLD;
          cnt_q   <= DIV_M2;
        end

        S_HOLD: begin
          if (cnt_q == '0) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end

        default: begin
          state_q <= S_IDLE;
          cs_n_q  <= 1'b1;
          sclk_q  <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign adc_cs_n     = cs_n_q;
  assign adc_sclk     = sclk_q;
  assign adc_din      = din_q;
  assign sample       = sample_q;
  assign sample_chan  = sample_chan_q;
  assign sample_valid = valid_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_adc_spi_reader.sv
module tb_adc_spi_reader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start, start2;
  logic [2:0]  channel, channel2;
  logic        adc_cs_n, adc_sclk, adc_din;
  logic        adc_dout = 1'b0;
  logic [11:0] sample;
  logic [2:0]  sample_chan;
  logic        sample_valid, busy;

  logic        cs2_n, sclk2, din2;
  logic        dout2 = 1'b0;
  logic [11:0] sample2;
  logic [2:0]  chan2;
  logic        valid2, busy2;

  always #5 clk = ~clk;

  adc_spi_reader dut (
    .clk(clk), .rst_n(rst_n), .start(start), .channel(channel),
    .adc_cs_n(adc_cs_n), .adc_sclk(adc_sclk), .adc_din(adc_din), .adc_dout(adc_dout),
    .sample(sample), .sample_chan(sample_chan), .sample_valid(sample_valid), .busy(busy)
  );

  adc_spi_reader #(.CLK_DIV(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .channel(channel2),
    .adc_cs_n(cs2_n), .adc_sclk(sclk2), .adc_din(din2), .adc_dout(dout2),
    .sample(sample2), .sample_chan(chan2), .sample_valid(valid2), .busy(busy2)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- ADC model (address-for-next-conversion) ----------------
  logic [11:0] chan_data [8];
  logic [3:0]  lead_q = 4'h0;
  logic [2:0]  m_prev = 3'd0;
  logic [15:0] m_word = '0;
  logic [15:0] din_cap = '0;
  logic [15:0] last_din = '0;
  int          m_idx = 15;

  always @(negedge adc_cs_n) begin
    m_word  = {lead_q, chan_data[m_prev]};
    m_idx   = 15;
    din_cap = '0;
  end
  always @(negedge adc_sclk) begin
    if (!adc_cs_n && m_idx >= 0) begin
      adc_dout = m_word[m_idx];
      m_idx--;
    end
  end
  always @(posedge adc_sclk) begin
    if (!adc_cs_n) din_cap = {din_cap[14:0], adc_din};
  end
  always @(posedge adc_cs_n) begin
    last_din = din_cap;
    m_prev   = din_cap[13:11];
  end

  // Fixed-word model for the CLK_DIV=2 instance.
  logic [15:0] w2 = 16'hFB7E;
  int          idx2 = 15;
  always @(negedge cs2_n) idx2 = 15;
  always @(negedge sclk2) begin
    if (!cs2_n && idx2 >= 0) begin
      dout2 = w2[idx2];
      idx2--;
    end
  end

  // ---------------- Bus monitor (samples on falling clk) ----------------
  int cyc = 0, cs_run = 0, rise_run = 0, last_cs_low = 0, last_rises = 0;
  int valid_total = 0, valid_run = 0, last_valid_width = 0;
  int valid_gap = 0, last_valid_cyc = 0;
  logic prev_cs = 1'b1, prev_sclk = 1'b1, prev_valid = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (!adc_cs_n) cs_run++;
    else if (!prev_cs) begin
      last_cs_low = cs_run;
      last_rises  = rise_run;
      cs_run      = 0;
      rise_run    = 0;
    end
    if (adc_sclk && !prev_sclk && !adc_cs_n) rise_run++;
    if (sample_valid) begin
      if (!prev_valid) begin
        valid_total++;
        valid_gap      = cyc - last_valid_cyc;
        last_valid_cyc = cyc;
      end
      valid_run++;
    end else if (prev_valid) begin
      last_valid_width = valid_run;
      valid_run        = 0;
    end
    prev_cs    = adc_cs_n;
    prev_sclk  = adc_sclk;
    prev_valid = sample_valid;
  end

  function automatic bit cond(input int sel);
    case (sel)
      0:       return sample_valid === 1'b1;
      1:       return busy === 1'b1;
      2:       return busy === 1'b0;
      default: return rise_run >= 8;
    endcase
  endfunction

  task automatic wait_for(input int sel, input int max);
    int n;
    n = 0;
    while (!cond(sel) && n < max) begin
      @(negedge clk);
      n++;
    end
    if (!cond(sel)) begin
      n_cmp++;
      n_err++;
      $display("FAIL wait_%0d: condition not reached, waited %0d clocks, required within %0d", sel, n, max);
    end
  endtask

  task automatic do_frame(input logic [2:0] ch, input logic [3:0] lead);
    wait_for(2, 300);
    lead_q = lead;
    @(negedge clk);
    channel = ch;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_for(0, 400);
    repeat (3) @(negedge clk);
  endtask

  typedef struct {
    logic [2:0]  ch;
    logic [3:0]  lead;
    logic [2:0]  exp_chan;
    logic [11:0] exp_sample;
    logic [15:0] exp_din;
  } vec_t;
  vec_t vecs [8];

  initial begin
    int vt, cl, nr, r0, r1;
    logic ps;
    bit got2;
    logic [2:0] nxt [3];
    logic [2:0] exp_tag [3];

    start = 1'b0; channel = '0; start2 = 1'b0; channel2 = '0;
    chan_data[0] = 12'hA5C; chan_data[1] = 12'hFFF; chan_data[2] = 12'h000; chan_data[3] = 12'h123;
    chan_data[4] = 12'h456; chan_data[5] = 12'h789; chan_data[6] = 12'h3C3; chan_data[7] = 12'hE01;
    vecs[0] = '{3'd5, 4'h0, 3'd0, 12'hA5C, 16'h2800};
    vecs[1] = '{3'd3, 4'h0, 3'd5, 12'h789, 16'h1800};
    vecs[2] = '{3'd7, 4'h0, 3'd3, 12'h123, 16'h3800};
    vecs[3] = '{3'd0, 4'hF, 3'd7, 12'hE01, 16'h0000};
    vecs[4] = '{3'd2, 4'hF, 3'd0, 12'hA5C, 16'h1000};
    vecs[5] = '{3'd1, 4'hF, 3'd2, 12'h000, 16'h0800};
    vecs[6] = '{3'd6, 4'hF, 3'd1, 12'hFFF, 16'h3000};
    vecs[7] = '{3'd6, 4'h0, 3'd6, 12'h3C3, 16'h3000};

    // Reset values
    #2 rst_n = 1'b0;
    #1;
    chk("rst_cs_n", adc_cs_n, 1);
    chk("rst_sclk", adc_sclk, 1);
    chk("rst_din", adc_din, 0);
    chk("rst_sample", sample, 0);
    chk("rst_chan", sample_chan, 0);
    chk("rst_valid", sample_valid, 0);
    chk("rst_busy", busy, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Table of single frames
    for (int i = 0; i < 8; i++) begin
      do_frame(vecs[i].ch, vecs[i].lead);
      chk($sformatf("v%0d_sample", i), sample, vecs[i].exp_sample);
      chk($sformatf("v%0d_chan", i), sample_chan, vecs[i].exp_chan);
      chk($sformatf("v%0d_cs_low", i), last_cs_low, 132);
      chk($sformatf("v%0d_sclk_rises", i), last_rises, 16);
      chk($sformatf("v%0d_valid_width", i), last_valid_width, 1);
      chk($sformatf("v%0d_din_word", i), last_din, vecs[i].exp_din);
    end

    // start pulsed and channel changed while busy
    wait_for(2, 300);
    @(negedge clk);
    channel = 3'd2;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (40) @(negedge clk);
    channel = 3'd5;
    start   = 1'b1;
    repeat (3) @(negedge clk);
    start = 1'b0;
    repeat (20) @(negedge clk);
    channel = 3'd7;
    vt = valid_total;
    wait_for(0, 400);
    repeat (3) @(negedge clk);
    wait_for(2, 50);
    repeat (20) @(negedge clk);
    chk("busy_ign_frames", valid_total, vt + 1);
    chk("busy_ign_idle", busy, 0);
    chk("busy_ign_din", last_din, 16'h1000);
    chk("busy_ign_chan", sample_chan, 3'd6);
    chk("busy_ign_hold", sample, 12'h3C3);

    // Reset in the middle of bit period 8
    wait_for(2, 300);
    @(negedge clk);
    channel = 3'd3;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_for(3, 200);
    repeat (6) @(negedge clk);
    vt = valid_total;
    rst_n = 1'b0;
    #1;
    chk("mrst_cs_n", adc_cs_n, 1);
    chk("mrst_sclk", adc_sclk, 1);
    chk("mrst_busy", busy, 0);
    chk("mrst_sample", sample, 0);
    chk("mrst_chan", sample_chan, 0);
    chk("mrst_valid", sample_valid, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("mrst_no_strobe", valid_total, vt);

    // Continuous conversion with start held high
    nxt[0] = 3'd6; nxt[1] = 3'd1; nxt[2] = 3'd1;
    exp_tag[0] = 3'd0; exp_tag[1] = 3'd3; exp_tag[2] = 3'd6;
    @(negedge clk);
    channel = 3'd3;
    start   = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wait_for(1, 20);
      channel = nxt[i];
      wait_for(0, 400);
      if (i == 2) start = 1'b0;
      repeat (2) @(negedge clk);
      chk($sformatf("cont%0d_chan", i), sample_chan, exp_tag[i]);
      if (i > 0) begin
        chk($sformatf("cont%0d_gap", i), valid_gap, 137);
        chk($sformatf("cont%0d_sample", i), sample, chan_data[exp_tag[i]]);
      end
      wait_for(2, 40);
    end
    repeat (3) @(negedge clk);
    chk("cont_width", last_valid_width, 1);

    // CLK_DIV = 2 instance
    got2 = 1'b0; cl = 0; nr = 0; r0 = 0; r1 = 0; ps = 1'b1;
    @(negedge clk);
    channel2 = 3'd5;
    start2   = 1'b1;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      start2 = 1'b0;
      if (!cs2_n) cl++;
      if (sclk2 && !ps && !cs2_n) begin
        nr++;
        if (nr == 1) r0 = n;
        if (nr == 2) r1 = n;
      end
      ps = sclk2;
      if (valid2) begin
        got2 = 1'b1;
        break;
      end
    end
    chk("div2_valid_seen", got2, 1);
    chk("div2_cs_low", cl, 66);
    chk("div2_rises", nr, 16);
    chk("div2_sclk_period", r1 - r0, 4);
    chk("div2_sample", sample2, 12'hB7E);
    chk("div2_chan", chan2, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
